// File: rtl/rop_types_pkg.sv
// Shared ROP state definitions: DCR word layout, the unpacked state struct
// and the helper that turns a flat readout vector into that struct.
package rop_types;

  localparam int ROP_DCR_WORDS = 16;

  localparam int CBUF_ADDR     = 0;
  localparam int CBUF_PITCH    = 1;
  localparam int CBUF_MASK     = 2;
  localparam int ZBUF_ADDR     = 3;
  localparam int ZBUF_PITCH    = 4;
  localparam int DEPTH         = 5;
  localparam int STENCIL_FRONT = 6;
  localparam int STENCIL_BACK  = 7;
  localparam int BLEND_MODE    = 8;
  localparam int BLEND_FUNC    = 9;
  localparam int BLEND_CONST   = 10;
  localparam int LOGIC_OP      = 11;

  typedef struct packed {
    logic [31:0] cbuf_addr;
    logic [31:0] cbuf_pitch;
    logic [31:0] cbuf_mask;
    logic [31:0] zbuf_addr;
    logic [31:0] zbuf_pitch;
    logic [31:0] depth;
    logic [31:0] stencil_front;
    logic [31:0] stencil_back;
    logic [31:0] blend_mode;
    logic [31:0] blend_func;
    logic [31:0] blend_const;
    logic [31:0] logic_op;
  } rop_dcrs_t;

  // Word 0 sits in the LSBs of the flat vector; words 12..15 are spare.
  function automatic rop_dcrs_t rop_dcr_unpack(input logic [ROP_DCR_WORDS*32-1:0] words);
    rop_dcrs_t d;
    d.cbuf_addr     = words[CBUF_ADDR*32     +: 32];
    d.cbuf_pitch    = words[CBUF_PITCH*32    +: 32];
    d.cbuf_mask     = words[CBUF_MASK*32     +: 32];
    d.zbuf_addr     = words[ZBUF_ADDR*32     +: 32];
    d.zbuf_pitch    = words[ZBUF_PITCH*32    +: 32];
    d.depth         = words[DEPTH*32         +: 32];
    d.stencil_front = words[STENCIL_FRONT*32 +: 32];
    d.stencil_back  = words[STENCIL_BACK*32  +: 32];
    d.blend_mode    = words[BLEND_MODE*32    +: 32];
    d.blend_func    = words[BLEND_FUNC*32    +: 32];
    d.blend_const   = words[BLEND_CONST*32   +: 32];
    d.logic_op      = words[LOGIC_OP*32      +: 32];
    return d;
  endfunction

endpackage

// File: rtl/rop_dcr_credit.sv
// In-flight fragment credit counter. Issue is accepted only while the owner
// allows it and credits remain; a retire with nothing in flight is a protocol
// error that leaves the count at zero.
module rop_dcr_credit #(
  parameter int MAX_INFLIGHT = 64,
  localparam int CNT_BITS    = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                accept_en,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                retire,
  output logic [CNT_BITS-1:0] inflight
);

  logic issue;

  assign issue_ready = accept_en && (inflight < CNT_BITS'(MAX_INFLIGHT));
  assign issue       = issue_valid && issue_ready;

  // Count up on accepted issue, down on retire; both together cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else if (issue && !retire) begin
      inflight <= inflight + 1'b1;
    end else if (!issue && retire && (inflight != '0)) begin
      inflight <= inflight - 1'b1;
    end
  end

  underflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(retire && !issue && (inflight == '0)));

endmodule

// File: rtl/rop_dcr_bank.sv
// Multi-render-target DCR state bank for the ROP front-end.
// Writes land in a per-target shadow copy which is promoted to the active copy
// only after all in-flight fragments retire (DRAIN then SWAP), so state never
// changes mid-draw.
// Build option ROP_DCR_SHADOW_EN: when defined, shadow storage is built and the
// commit copies it to active; when undefined, writes go straight to active and
// the commit is only a drain barrier.
module rop_dcr_bank
  import rop_types::*;
#(
  parameter int NUM_RTS       = 4,
  parameter int DCR_WORDS     = ROP_DCR_WORDS,
  parameter int MAX_INFLIGHT  = 64,
  localparam int RT_BITS      = (NUM_RTS > 1) ? $clog2(NUM_RTS) : 1,
  localparam int WORD_BITS    = (DCR_WORDS > 1) ? $clog2(DCR_WORDS) : 1,
  localparam int CNT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dcr_wr_valid,
  input  logic [RT_BITS+WORD_BITS-1:0] dcr_wr_addr,
  input  logic [31:0]                  dcr_wr_data,
  input  logic                         commit_req,
  output logic                         commit_busy,
  output logic                         commit_done,
  input  logic                         frag_issue_valid,
  output logic                         frag_issue_ready,
  input  logic                         frag_retire,
  output logic [CNT_BITS-1:0]          inflight,
  input  logic [RT_BITS-1:0]           rd_rt_idx,
  output logic [DCR_WORDS*32-1:0]      rd_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  logic [1:0]           state;
  logic [RT_BITS-1:0]   wr_rt;
  logic [WORD_BITS-1:0] wr_word;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [RT_BITS-1:0]   rd_sel;
  logic [31:0]          active_q [NUM_RTS][DCR_WORDS];

  assign wr_rt   = dcr_wr_addr[WORD_BITS +: RT_BITS];
  assign wr_word = dcr_wr_addr[WORD_BITS-1:0];
  assign wr_ok   = dcr_wr_valid && (int'(wr_rt) < NUM_RTS) && (int'(wr_word) < DCR_WORDS);

  assign rd_ok  = int'(rd_rt_idx) < NUM_RTS;
  assign rd_sel = rd_ok ? rd_rt_idx : '0;

  assign commit_busy = (state != ST_IDLE);

  rop_dcr_credit #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clk         (clk),
    .reset       (reset),
    .accept_en   (state == ST_IDLE),
    .issue_valid (frag_issue_valid),
    .issue_ready (frag_issue_ready),
    .retire      (frag_retire),
    .inflight    (inflight)
  );

  // Commit sequencer: requests outside IDLE are dropped, DRAIN waits for zero credits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (commit_req) state <= ST_DRAIN;
        ST_DRAIN: if (inflight == '0) state <= ST_SWAP;
        ST_SWAP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Completion pulse follows the SWAP cycle by one register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_done <= 1'b0;
    end else begin
      commit_done <= (state == ST_SWAP);
    end
  end

`ifdef ROP_DCR_SHADOW_EN
  logic [31:0] shadow_q [NUM_RTS][DCR_WORDS];

  // Shadow capture accepts in-range writes in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_RTS; r++)
        for (int w = 0; w < DCR_WORDS; w++)
          shadow_q[r][w] <= '0;
    end else if (wr_ok) begin
      shadow_q[wr_rt][wr_word] <= dcr_wr_data;
    end
  end

  // Promotion copies every target at once; a write landing in SWAP is forwarded in.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_RTS; r++)
        for (int w = 0; w < DCR_WORDS; w++)
          active_q[r][w] <= '0;
    end else if (state == ST_SWAP) begin
      for (int r = 0; r < NUM_RTS; r++)
        for (int w = 0; w < DCR_WORDS; w++)
          active_q[r][w] <= (wr_ok && (int'(wr_rt) == r) && (int'(wr_word) == w))
                            ? dcr_wr_data : shadow_q[r][w];
    end
  end
`else
  // Without shadowing, writes update the active copy directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_RTS; r++)
        for (int w = 0; w < DCR_WORDS; w++)
          active_q[r][w] <= '0;
    end else if (wr_ok) begin
      active_q[wr_rt][wr_word] <= dcr_wr_data;
    end
  end
`endif

  // Registered readout of the selected target; unknown targets read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      for (int w = 0; w < DCR_WORDS; w++)
        rd_data[w*32 +: 32] <= rd_ok ? active_q[rd_sel][w] : 32'h0;
    end
  end

endmodule
